// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: command codes, SR bit
// positions and the response-slot state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: ptr picks the winner on contention, a sole
// requester always wins. Purely combinational; en gates the grant.
module rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = (&req) ? ptr : req[1];
        gnt    = 2'b00;
        if (en && (|req)) begin
            gnt = id_to_onehot(gnt_id);
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between the execute stage (0) and the
// aux/debug unit (1); owns SR and a single registered response slot.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int         DW     = 32,
    parameter logic [3:0] SR_RST = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [7:0]      req_cmd,
    input  logic [2*DW-1:0] req_val1,
    input  logic [2*DW-1:0] req_val2,
    input  logic [1:0]      req_s,
    output logic [3:0]      alu_cmd,
    output logic [3:0]      alu_sr,
    output logic [DW-1:0]   alu_val1,
    output logic [DW-1:0]   alu_val2,
    input  logic [3:0]      alu_status,
    input  logic [DW-1:0]   alu_result,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_result,
    output logic [3:0]      rsp_status,
    input  logic            rsp_ready,
    output logic [3:0]      sr
);

    state_t     state_q;
    state_t     state_d;
    logic       rr_ptr;
    logic       slot_free;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       granted;
    logic       sel;

    // A grant may land in the same cycle the consumer drains the slot.
    assign slot_free = (state_q == ST_IDLE) || (rsp_valid && rsp_ready);

    rr_arb2 u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .en     (slot_free && !rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign granted   = |gnt;
    assign req_ready = gnt;
    assign rsp_valid = (state_q == ST_FULL);

    // With no grant the ALU still sees requester rr_ptr; its output is ignored.
    assign sel      = granted ? gnt_id : rr_ptr;
    assign alu_cmd  = sel ? req_cmd[7:4]          : req_cmd[3:0];
    assign alu_val1 = sel ? req_val1[2*DW-1:DW]   : req_val1[DW-1:0];
    assign alu_val2 = sel ? req_val2[2*DW-1:DW]   : req_val2[DW-1:0];
    assign alu_sr   = sr;

    always_comb begin
        state_d = state_q;
        if (granted) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr         <= SR_RST;
            rr_ptr     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_status <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (granted) begin
                rsp_id     <= gnt_id;
                rsp_result <= alu_result;
                rsp_status <= alu_status;
                rr_ptr     <= ~gnt_id;
                if (req_s[gnt_id]) begin
                    sr <= alu_status;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU stub in the loop;
// expected values are hand-computed per vector.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_cmd;
    logic [63:0] req_val1;
    logic [63:0] req_val2;
    logic [1:0]  req_s;
    logic [3:0]  alu_cmd;
    logic [3:0]  alu_sr;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [3:0]  alu_status;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_status;
    logic        rsp_ready;
    logic [3:0]  sr;

    int n_chk = 0;
    int n_err = 0;
    logic [3:0] exp_sr_now;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DW(32), .SR_RST(4'b0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_val1   (req_val1),
        .req_val2   (req_val2),
        .req_s      (req_s),
        .alu_cmd    (alu_cmd),
        .alu_sr     (alu_sr),
        .alu_val1   (alu_val1),
        .alu_val2   (alu_val2),
        .alu_status (alu_status),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .rsp_ready  (rsp_ready),
        .sr         (sr)
    );

    // ALU stub: MOV/MVN take Val2; subtract C out is borrow; SBC uses ARM-style ~C as borrow-in.
    logic [32:0] t;
    logic        v;
    always_comb begin
        t = 33'd0;
        v = 1'b0;
        case (alu_cmd)
            CMD_MOV: t = {1'b0, alu_val2};
            CMD_MVN: t = {1'b0, ~alu_val2};
            CMD_ADD: begin
                t = {1'b0, alu_val1} + {1'b0, alu_val2};
                v = (alu_val1[31] == alu_val2[31]) && (t[31] != alu_val1[31]);
            end
            CMD_ADC: begin
                t = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'd0, alu_sr[SR_C]};
                v = (alu_val1[31] == alu_val2[31]) && (t[31] != alu_val1[31]);
            end
            CMD_SUB: begin
                t = {1'b0, alu_val1} - {1'b0, alu_val2};
                v = (alu_val1[31] != alu_val2[31]) && (t[31] != alu_val1[31]);
            end
            CMD_SBC: begin
                t = {1'b0, alu_val1} - {1'b0, alu_val2} - {32'd0, ~alu_sr[SR_C]};
                v = (alu_val1[31] != alu_val2[31]) && (t[31] != alu_val1[31]);
            end
            CMD_AND: t = {1'b0, alu_val1 & alu_val2};
            CMD_ORR: t = {1'b0, alu_val1 | alu_val2};
            CMD_EOR: t = {1'b0, alu_val1 ^ alu_val2};
            default: t = 33'd0;
        endcase
        alu_result = t[31:0];
        alu_status = {t[31], (t[31:0] == 32'd0), t[32], v};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        if (id) begin
            req_cmd[7:4] = cmd; req_val1[63:32] = a; req_val2[63:32] = b; req_s[1] = s;
        end else begin
            req_cmd[3:0] = cmd; req_val1[31:0]  = a; req_val2[31:0]  = b; req_s[0] = s;
        end
    endtask

    // One granted op from a single requester; checks grant, ALU SR feed and the registered response.
    task automatic do_op(input string tag, input logic id, input logic [3:0] cmd,
                         input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] exp_res, input logic [3:0] exp_st,
                         input logic [3:0] exp_sr);
        set_req(id, cmd, a, b, s);
        req_valid = id ? 2'b10 : 2'b01;
        @(negedge clk);
        chk({tag, "/rdy"}, {30'd0, req_ready}, id ? 32'd2 : 32'd1);
        chk({tag, "/alu_sr"}, {28'd0, alu_sr}, {28'd0, exp_sr_now});
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk({tag, "/vld"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "/id"}, {31'd0, rsp_id}, {31'd0, id});
        chk({tag, "/res"}, rsp_result, exp_res);
        chk({tag, "/st"}, {28'd0, rsp_status}, {28'd0, exp_st});
        chk({tag, "/sr"}, {28'd0, sr}, {28'd0, exp_sr});
        exp_sr_now = exp_sr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sr_now = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_cmd = '0; req_val1 = '0; req_val2 = '0;
        req_s = 2'b00; rsp_ready = 1'b1; exp_sr_now = 4'b0000;
        do_reset();

        chk("rst/vld", {31'd0, rsp_valid}, 32'd0);
        chk("rst/id", {31'd0, rsp_id}, 32'd0);
        chk("rst/res", rsp_result, 32'd0);
        chk("rst/st", {28'd0, rsp_status}, 32'd0);
        chk("rst/sr", {28'd0, sr}, 32'd0);
        chk("rst/rdy", {30'd0, req_ready}, 32'd0);

        // Overflowing add sets N and V
        do_op("t1_add", 1'b0, CMD_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 4'b1001, 4'b1001);
        @(posedge clk); #1;
        chk("t1/drain_vld", {31'd0, rsp_valid}, 32'd0);

        // Round-robin from reset: 0,1,0,1 with no bubbles
        do_reset();
        set_req(1'b0, CMD_ADD, 32'd1, 32'd0, 1'b0);
        set_req(1'b1, CMD_ADD, 32'd2, 32'd0, 1'b0);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2/rdy", {30'd0, req_ready}, (i % 2) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            chk("t2/id", {31'd0, rsp_id}, (i % 2) ? 32'd1 : 32'd0);
            chk("t2/res", rsp_result, (i % 2) ? 32'd2 : 32'd1);
            chk("t2/vld", {31'd0, rsp_valid}, 32'd1);
        end
        req_valid = 2'b00;

        // Carry chain: set C, ADC sees it, then clear C and SBC borrows
        do_op("t3_setc", 1'b0, CMD_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b0110, 4'b0110);
        do_op("t3_adc", 1'b0, CMD_ADC, 32'd1, 32'd1, 1'b0, 32'd3, 4'b0000, 4'b0110);
        do_op("t3_clrc", 1'b1, CMD_MOV, 32'd0, 32'd5, 1'b1, 32'd5, 4'b0000, 4'b0000);
        do_op("t3_sbc", 1'b0, CMD_SBC, 32'd5, 32'd2, 1'b0, 32'd2, 4'b0000, 4'b0000);

        // Back-pressure: response held, no grant, then same-cycle grant on release
        do_op("t4_mov", 1'b0, CMD_MOV, 32'd0, 32'h55, 1'b0, 32'h55, 4'b0000, 4'b0000);
        rsp_ready = 1'b0;
        set_req(1'b1, CMD_MOV, 32'd0, 32'hAA, 1'b1);
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4/hold_rdy", {30'd0, req_ready}, 32'd0);
            chk("t4/hold_vld", {31'd0, rsp_valid}, 32'd1);
            chk("t4/hold_res", rsp_result, 32'h55);
            chk("t4/hold_id", {31'd0, rsp_id}, 32'd0);
            @(posedge clk); #1;
        end
        chk("t4/hold_sr", {28'd0, sr}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4/rel_rdy", {30'd0, req_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("t4/rel_vld", {31'd0, rsp_valid}, 32'd1);
        chk("t4/rel_res", rsp_result, 32'hAA);
        chk("t4/rel_id", {31'd0, rsp_id}, 32'd1);

        // Z from SUB, s=0 leaves SR alone, unknown cmd still updates SR
        do_op("t5_sub", 1'b0, CMD_SUB, 32'd5, 32'd5, 1'b1, 32'd0, 4'b0100, 4'b0100);
        do_op("t5_mov0", 1'b0, CMD_MOV, 32'd0, 32'd0, 1'b0, 32'd0, 4'b0100, 4'b0100);
        do_op("t5_movn", 1'b1, CMD_MOV, 32'd0, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b1000, 4'b0100);
        do_op("t5_movs", 1'b1, CMD_MOV, 32'd0, 32'h8000_0000, 1'b1, 32'h8000_0000, 4'b1000, 4'b1000);
        do_op("t5_unk", 1'b0, 4'b1111, 32'd9, 32'd9, 1'b1, 32'd0, 4'b0100, 4'b0100);

        // Reset mid-operation with both requesters held across it
        do_op("t6_add", 1'b0, CMD_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 4'b1001, 4'b1001);
        rsp_ready = 1'b0;
        set_req(1'b0, CMD_MOV, 32'd0, 32'd3, 1'b0);
        set_req(1'b1, CMD_MOV, 32'd0, 32'd7, 1'b0);
        req_valid = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        chk("t6/rst_rdy", {30'd0, req_ready}, 32'd0);
        chk("t6/pre_vld", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("t6/post_vld", {31'd0, rsp_valid}, 32'd0);
        chk("t6/post_sr", {28'd0, sr}, 32'd0);
        chk("t6/post_res", rsp_result, 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t6/rel_rdy", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("t6/rel_id", {31'd0, rsp_id}, 32'd0);
        chk("t6/rel_res", rsp_result, 32'd3);
        chk("t6/rel_vld", {31'd0, rsp_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
